digest_stream_out: RTL and testbench

- Downstream consumer of the 2-cycle falling-edge pulse produced when the SHA-512 core deasserts busy.
- On that pulse, captures the 512-bit digest and streams it out MS word first as WORD_W-bit words over a valid/ready interface, e.g. toward a UART/AXI-stream bridge.
- Collapses the multi-cycle start pulse into a single event.
- Flags any start events that arrive while a stream is in progress.

---
 rtl/digest_stream_out_if.sv | 23 ++
 rtl/digest_stream_out.sv | 130 +++++++++++++
 tb/tb_digest_stream_out.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/digest_stream_out_if.sv
// Valid/ready word stream carrying digest words from the serializer to its sink.
interface digest_stream_out_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/digest_stream_out.sv
// Captures a hash digest on the rising edge of start and streams it MS word first
// over a valid/ready interface; start events that arrive mid-stream set a sticky overrun.
module digest_stream_out #(
    parameter int unsigned DIGEST_W = 512,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIGEST_W-1:0]      digest_in,
    digest_stream_out_if.master      out_if,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int unsigned N_WORDS = DIGEST_W / WORD_W;
    localparam int unsigned CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
    localparam logic ONE_WORD = (N_WORDS == 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DIGEST_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                overrun_q, overrun_d;
    logic                start_prev_q, start_prev_d;
    logic                prev_vld_q, prev_vld_d;

    logic start_evt;
    logic xfer;
    logic final_xfer;

    // start_prev only counts as history once start has been seen low after reset,
    // so a start already high at reset release never fires.
    assign start_evt  = start & ~start_prev_q & prev_vld_q;
    assign xfer       = valid_q & out_if.out_ready;
    assign final_xfer = xfer & (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            overrun_q    <= 1'b0;
            start_prev_q <= 1'b0;
            prev_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            overrun_q    <= overrun_d;
            start_prev_q <= start_prev_d;
            prev_vld_q   <= prev_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        last_d       = last_q;
        overrun_d    = overrun_q;
        start_prev_d = start;
        prev_vld_d   = prev_vld_q | ~start;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_evt) begin
                    shift_d = digest_in;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    last_d  = ONE_WORD;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (final_xfer) begin
                    // A new digest landing exactly on the final transfer is taken without a gap.
                    if (start_evt) begin
                        shift_d = digest_in;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        last_d  = ONE_WORD;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        shift_d = shift_q << WORD_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                        last_d  = ((cnt_q + CNT_W'(1)) == LAST_IDX);
                    end
                    if (start_evt) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign out_if.out_data  = shift_q[DIGEST_W-1 -: WORD_W];
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = valid_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_digest_stream_out.sv
// Directed bench for digest_stream_out: scoreboard of expected words, checked on every
// cycle the stream presents a word.
module tb_digest_stream_out;

    localparam int unsigned DIGEST_W = 512;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned N_WORDS  = DIGEST_W / WORD_W;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic              last;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [DIGEST_W-1:0] digest_in;
    logic                busy;
    logic                overrun;
    logic                overrun_clr;

    digest_stream_out_if #(.WORD_W(WORD_W)) sif ();

    digest_stream_out #(
        .DIGEST_W (DIGEST_W),
        .WORD_W   (WORD_W)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .digest_in   (digest_in),
        .out_if      (sif.master),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   start_left = 0;
    int   cyc        = 0;
    bit   bp         = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    logic [DIGEST_W-1:0] d_inc;
    logic [DIGEST_W-1:0] d_ones;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_digest(input logic [DIGEST_W-1:0] d);
        exp_t e;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            e.data = d[DIGEST_W-1-WORD_W*i -: WORD_W];
            e.last = (i == int'(N_WORDS) - 1);
            q.push_back(e);
        end
    endtask

    // One clock: compare the presented word at the falling edge, then advance inputs.
    task automatic step();
        @(negedge clk);
        if (sif.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'(sif.out_valid), 64'd0);
            end else begin
                chk("word_data", 64'(sif.out_data), 64'(q[0].data));
                chk("word_last", 64'(sif.out_last), 64'(q[0].last));
                chk("busy_streaming", 64'(busy), 64'd1);
                if (sif.out_ready) void'(q.pop_front());
            end
        end else begin
            chk("last_without_valid", 64'(sif.out_last), 64'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (start_left > 0) begin
            start_left--;
            if (start_left == 0) start = 1'b0;
        end
        sif.out_ready = bp ? ready_pat[cyc % 4] : 1'b1;
    endtask

    task automatic fire_start(input logic [DIGEST_W-1:0] d, input int cycles, input bit expect_accept);
        digest_in  = d;
        start      = 1'b1;
        start_left = cycles;
        if (expect_accept) push_digest(d);
    endtask

    task automatic wait_q(input int sz);
        int n = 0;
        while (q.size() > sz && n < 400) begin
            step();
            n++;
        end
        chk("wait_timeout", 64'(q.size() > sz), 64'd0);
    endtask

    task automatic drain();
        wait_q(0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(sif.out_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy),          64'd0);
        chk({tag, "_last"},  64'(sif.out_last),  64'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(DIGEST_W / 8); i++) d_inc[DIGEST_W-1-8*i -: 8] = 8'(i);
        d_ones        = '1;
        rst_n         = 1'b0;
        start         = 1'b1;
        digest_in     = '0;
        overrun_clr   = 1'b0;
        sif.out_ready = 1'b1;

        // Reset values, with start held high across release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",    64'(sif.out_data), 64'd0);
        chk_idle("rst");
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("start_high_at_release", 64'(busy), 64'd0);
        start = 1'b0;
        step();

        // Basic stream with one-cycle latency.
        fire_start(d_inc, 2, 1'b1);
        chk("pre_latency_valid", 64'(sif.out_valid), 64'd0);
        step();
        chk("latency_valid", 64'(sif.out_valid), 64'd1);
        chk("first_word", 64'(sif.out_data), 64'h0001_0203);
        drain();
        chk_idle("basic_end");

        // Backpressure, ready pattern 1,0,0,1.
        bp = 1'b1;
        fire_start(d_inc, 2, 1'b1);
        drain();
        bp = 1'b0;
        sif.out_ready = 1'b1;
        chk_idle("bp_end");

        // Long start yields exactly one stream.
        fire_start(d_inc, 40, 1'b1);
        drain();
        while (start_left > 0) step();
        repeat (3) step();
        chk("long_overrun", 64'(overrun), 64'd0);
        chk_idle("long_end");

        // Overrun at word 5, then clear.
        fire_start(d_inc, 2, 1'b1);
        wait_q(11);
        fire_start(d_ones, 2, 1'b0);
        drain();
        chk("overrun_set", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 64'(overrun), 64'd0);

        // Set and clear in the same cycle: set wins.
        fire_start(d_inc, 2, 1'b1);
        wait_q(10);
        fire_start(d_ones, 2, 1'b0);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_set_wins", 64'(overrun), 64'd1);
        drain();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared2", 64'(overrun), 64'd0);

        // Back-to-back: new start on the final transfer.
        fire_start(d_inc, 2, 1'b1);
        wait_q(N_WORDS + 1 - 1);
        wait_q(1);
        fire_start(d_ones, 2, 1'b1);
        step();
        chk("b2b_valid",   64'(sif.out_valid), 64'd1);
        chk("b2b_data",    64'(sif.out_data),  64'hFFFF_FFFF);
        chk("b2b_overrun", 64'(overrun),       64'd0);
        drain();
        chk("b2b_overrun_end", 64'(overrun), 64'd0);
        chk_idle("b2b_end");

        // Reset at word 7 with overrun pending.
        fire_start(d_inc, 2, 1'b1);
        wait_q(12);
        fire_start(d_ones, 2, 1'b0);
        wait_q(9);
        chk("pre_reset_overrun", 64'(overrun), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_overrun", 64'(overrun), 64'd0);
        chk("midrst_data",    64'(sif.out_data), 64'd0);
        q.delete();
        start      = 1'b0;
        start_left = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        chk("post_reset_idle", 64'(busy), 64'd0);
        fire_start(d_inc, 2, 1'b1);
        drain();
        chk_idle("post_reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
